// File: rtl/quad_decoder_if.sv
// Per-axis bundle between the encoder pins / register file and quad_decoder.
// master drives pins and register controls; slave is the decoder itself.
interface quad_decoder_if #(
   parameter int unsigned COUNT_BITS = 32
) ();

   logic                  quadA;
   logic                  quadB;
   logic                  quadZ;
   logic                  load;
   logic [COUNT_BITS-1:0] load_value;
   logic                  err_clear;
   logic [COUNT_BITS-1:0] position;
   logic                  dir;
   logic                  error;
   logic [COUNT_BITS-1:0] index_pos;
   logic                  index_valid;

   modport master (
      output quadA, quadB, quadZ, load, load_value, err_clear,
      input  position, dir, error, index_pos, index_valid
   );

   modport slave (
      input  quadA, quadB, quadZ, load, load_value, err_clear,
      output position, dir, error, index_pos, index_valid
   );

endinterface

// File: rtl/quad_decoder.sv
// Synchronised, glitch-filtered 4x quadrature decoder with signed loadable position counter.
// Define QUAD_INDEX_EN to build the Z index capture (and optional clear) path.
module quad_decoder #(
   parameter int unsigned COUNT_BITS  = 32,
   parameter int unsigned FILTER_LEN  = 3,
   parameter int unsigned INDEX_CLEAR = 0
) (
   input logic           clk,
   input logic           rst,
   quad_decoder_if.slave bus
);

`ifdef QUAD_INDEX_EN
   localparam int unsigned NumIn = 3;
`else
   localparam int unsigned NumIn = 2;
`endif
   localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
   localparam int unsigned WarmW = $clog2(FILTER_LEN + 3);

   typedef enum logic [0:0] {StWarmup, StRun} state_e;

   state_e               state_q;
   logic [WarmW-1:0]     warm_q;
   logic [NumIn-1:0]     pins;
   logic [NumIn-1:0]     sync1_q;
   logic [NumIn-1:0]     sync2_q;
   logic [NumIn-1:0]     filt_q;
   logic [NumIn-1:0]     prev_q;
   logic [FiltW-1:0]     cnt_q [NumIn];

   logic [COUNT_BITS-1:0] pos_q;
   logic [COUNT_BITS-1:0] pos_pre;
   logic [COUNT_BITS-1:0] pos_d;
   logic                  dir_q;
   logic                  err_q;
   logic                  run;
   logic [1:0]            phase_diff;
   logic                  step_up;
   logic                  step_dn;
   logic                  illegal;
   logic                  index_evt;

   // Gray phase index along the up sequence 00 -> 10 -> 11 -> 01 (bits are {A,B}).
   function automatic logic [1:0] phase(input logic [1:0] ab);
      logic [1:0] p;
      case (ab)
         2'b00:   p = 2'd0;
         2'b10:   p = 2'd1;
         2'b11:   p = 2'd2;
         default: p = 2'd3;
      endcase
      return p;
   endfunction

`ifdef QUAD_INDEX_EN
   assign pins = {bus.quadZ, bus.quadB, bus.quadA};
`else
   assign pins = {bus.quadB, bus.quadA};
`endif

   // Input path: 2-flop synchroniser, then a per-input persistence filter.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         filt_q  <= '0;
         prev_q  <= '0;
         for (int i = 0; i < NumIn; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= pins;
         sync2_q <= sync1_q;
         prev_q  <= filt_q;
         for (int i = 0; i < NumIn; i++) begin
            if (state_q == StWarmup) begin
               filt_q[i] <= sync2_q[i];
               cnt_q[i]  <= '0;
            end else if (sync2_q[i] == filt_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == FiltW'(FILTER_LEN - 1)) begin
               filt_q[i] <= sync2_q[i];
               cnt_q[i]  <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + FiltW'(1);
            end
         end
      end
   end

   assign run        = (state_q == StRun);
   assign phase_diff = phase({filt_q[0], filt_q[1]}) - phase({prev_q[0], prev_q[1]});
   assign step_up    = run && (phase_diff == 2'd1);
   assign step_dn    = run && (phase_diff == 2'd3);
   assign illegal    = run && (phase_diff == 2'd2);

`ifdef QUAD_INDEX_EN
   assign index_evt = run && filt_q[2] && !prev_q[2];
`else
   assign index_evt = 1'b0;
`endif

   always_comb begin
      pos_pre = pos_q;
      if (bus.load) begin
         pos_pre = bus.load_value;
      end else if (step_up) begin
         pos_pre = pos_q + COUNT_BITS'(1);
      end else if (step_dn) begin
         pos_pre = pos_q - COUNT_BITS'(1);
      end
      pos_d = pos_pre;
      // Index clear discards any step but never overrides a load.
      if (index_evt && (INDEX_CLEAR != 0) && !bus.load) pos_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StWarmup;
         warm_q  <= '0;
         pos_q   <= '0;
         dir_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StWarmup: begin
               if (warm_q == WarmW'(FILTER_LEN + 2)) state_q <= StRun;
               else warm_q <= warm_q + WarmW'(1);
            end
            StRun: state_q <= StRun;
            default: state_q <= StWarmup;
         endcase
         pos_q <= pos_d;
         if (step_up || step_dn) dir_q <= step_up;
         if (illegal) err_q <= 1'b1;
         else if (bus.err_clear) err_q <= 1'b0;
      end
   end

   assign bus.position = pos_q;
   assign bus.dir      = dir_q;
   assign bus.error    = err_q;

`ifdef QUAD_INDEX_EN
   logic [COUNT_BITS-1:0] idx_pos_q;
   logic                  idx_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_pos_q   <= '0;
         idx_valid_q <= 1'b0;
      end else begin
         idx_valid_q <= index_evt;
         if (index_evt) idx_pos_q <= pos_pre;
      end
   end

   assign bus.index_pos   = idx_pos_q;
   assign bus.index_valid = idx_valid_q;
`else
   logic unused_index;
   assign unused_index    = bus.quadZ ^ (INDEX_CLEAR != 0) ^ index_evt;
   assign bus.index_pos   = '0;
   assign bus.index_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: directed pin sequences push expected snapshots,
// a negedge monitor compares them (and every index_valid pulse) when they fall due.
module tb_quad_decoder;

   localparam int unsigned CB  = 32;
   localparam int unsigned FL  = 3;
   localparam int unsigned LAT = FL + 3;

   logic        clk = 1'b0;
   logic        rst;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   quad_decoder_if #(.COUNT_BITS(CB)) bus ();

   quad_decoder #(
      .COUNT_BITS (CB),
      .FILTER_LEN (FL),
      .INDEX_CLEAR(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string         name;
      int unsigned   due;
      logic [CB-1:0] pos;
      logic          dir;
      logic          err;
      logic [CB-1:0] idx;
      logic          iv;
   } exp_t;

   exp_t          exp_q[$];
   logic [CB-1:0] idx_q[$];
   exp_t          cur;
   logic [CB-1:0] cur_idx;

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         cur = exp_q.pop_front();
         checks++;
         if (cur.due != cyc || bus.position !== cur.pos || bus.dir !== cur.dir ||
             bus.error !== cur.err || bus.index_pos !== cur.idx ||
             bus.index_valid !== cur.iv) begin
            errors++;
            $display("FAIL %s @cyc %0d: got pos=%h dir=%b err=%b idx=%h iv=%b, want pos=%h dir=%b err=%b idx=%h iv=%b (due %0d)",
                     cur.name, cyc, bus.position, bus.dir, bus.error, bus.index_pos,
                     bus.index_valid, cur.pos, cur.dir, cur.err, cur.idx, cur.iv, cur.due);
         end
      end
      if (bus.index_valid === 1'b1) begin
         checks++;
         if (idx_q.size() == 0) begin
            errors++;
            $display("FAIL index_pulse @cyc %0d: got unexpected pulse idx=%h, want none",
                     cyc, bus.index_pos);
         end else begin
            cur_idx = idx_q.pop_front();
            if (bus.index_pos !== cur_idx) begin
               errors++;
               $display("FAIL index_pulse @cyc %0d: got idx=%h, want %h", cyc, bus.index_pos,
                        cur_idx);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ab(input logic a, input logic b);
      bus.quadA = a;
      bus.quadB = b;
   endtask

   task automatic chk(input string n, input int unsigned dly, input logic [CB-1:0] p,
                      input logic d, input logic e, input logic [CB-1:0] ix, input logic iv);
      exp_t x;
      x.name = n;
      x.due  = cyc + dly;
      x.pos  = p;
      x.dir  = d;
      x.err  = e;
      x.idx  = ix;
      x.iv   = iv;
      exp_q.push_back(x);
   endtask

   task automatic pulse_load(input logic [CB-1:0] v);
      bus.load       = 1'b1;
      bus.load_value = v;
      tick(1);
      bus.load = 1'b0;
   endtask

   logic [1:0] up_seq [4];

   initial begin
      up_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
      rst            = 1'b1;
      bus.quadA      = 1'b0;
      bus.quadB      = 1'b0;
      bus.quadZ      = 1'b0;
      bus.load       = 1'b0;
      bus.load_value = '0;
      bus.err_clear  = 1'b0;
      tick(3);
      chk("reset", 0, '0, 1'b0, 1'b0, '0, 1'b0);
      rst = 1'b0;
      tick(12);

      // Eight up-steps; the first one checked for exact latency.
      set_ab(1'b1, 1'b0);
      chk("up1_before", LAT - 1, '0, 1'b0, 1'b0, '0, 1'b0);
      chk("up1_after", LAT, 32'd1, 1'b1, 1'b0, '0, 1'b0);
      tick(10);
      for (int i = 1; i < 8; i++) begin
         set_ab(up_seq[i % 4][1], up_seq[i % 4][0]);
         tick(10);
         if (i == 3) chk("up4", 0, 32'd4, 1'b1, 1'b0, '0, 1'b0);
      end
      chk("up8", 0, 32'd8, 1'b1, 1'b0, '0, 1'b0);

      pulse_load('0);
      chk("load0", 0, '0, 1'b1, 1'b0, '0, 1'b0);
      set_ab(1'b0, 1'b1);
      tick(10);
      chk("down_to_neg1", 0, '1, 1'b0, 1'b0, '0, 1'b0);
      pulse_load(32'h7FFF_FFFF);
      chk("load_max", 0, 32'h7FFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
      set_ab(1'b0, 1'b0);
      tick(10);
      chk("max_plus1", 0, 32'h8000_0000, 1'b1, 1'b0, '0, 1'b0);
      set_ab(1'b0, 1'b1);
      tick(10);
      chk("min_minus1", 0, 32'h7FFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
      set_ab(1'b0, 1'b0);
      tick(10);
      chk("wrap_back", 0, 32'h8000_0000, 1'b1, 1'b0, '0, 1'b0);

      bus.quadA = 1'b1;
      tick(2);
      bus.quadA = 1'b0;
      tick(10);
      chk("glitch", 0, 32'h8000_0000, 1'b1, 1'b0, '0, 1'b0);

      set_ab(1'b1, 1'b1);
      tick(10);
      chk("illegal", 0, 32'h8000_0000, 1'b1, 1'b1, '0, 1'b0);
      bus.err_clear = 1'b1;
      tick(1);
      bus.err_clear = 1'b0;
      chk("err_clear", 0, 32'h8000_0000, 1'b1, 1'b0, '0, 1'b0);

      // err_clear lands on the same edge as a second illegal jump.
      set_ab(1'b0, 1'b0);
      tick(LAT - 1);
      chk("set_wins_pre", 0, 32'h8000_0000, 1'b1, 1'b0, '0, 1'b0);
      bus.err_clear = 1'b1;
      tick(1);
      bus.err_clear = 1'b0;
      chk("set_wins", 0, 32'h8000_0000, 1'b1, 1'b1, '0, 1'b0);
      tick(10);
      bus.err_clear = 1'b1;
      tick(1);
      bus.err_clear = 1'b0;

      set_ab(1'b0, 1'b1);
      tick(10);
      chk("down_pre_load", 0, 32'h7FFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
      set_ab(1'b0, 1'b0);
      tick(LAT - 1);
      pulse_load(32'd100);
      chk("load_wins", 0, 32'd100, 1'b1, 1'b0, '0, 1'b0);
      tick(10);
      chk("load_hold", 0, 32'd100, 1'b1, 1'b0, '0, 1'b0);

      pulse_load(32'd57);
      tick(2);
      bus.quadZ = 1'b1;
`ifdef QUAD_INDEX_EN
      idx_q.push_back(32'd57);
      chk("idx_pre", LAT - 1, 32'd57, 1'b1, 1'b0, '0, 1'b0);
      chk("idx_evt", LAT, '0, 1'b1, 1'b0, 32'd57, 1'b1);
      chk("idx_post", LAT + 1, '0, 1'b1, 1'b0, 32'd57, 1'b0);
`else
      chk("idx_pre", LAT - 1, 32'd57, 1'b1, 1'b0, '0, 1'b0);
      chk("idx_evt", LAT, 32'd57, 1'b1, 1'b0, '0, 1'b0);
      chk("idx_post", LAT + 1, 32'd57, 1'b1, 1'b0, '0, 1'b0);
`endif
      tick(10);
      bus.quadZ = 1'b0;
      tick(10);

      // Inputs held at 11 through reset: warm-up must not count from 00.
      set_ab(1'b1, 1'b1);
      rst = 1'b1;
      tick(3);
      chk("reset2", 0, '0, 1'b0, 1'b0, '0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < int'(FL) + 6; i++) begin
         tick(1);
         chk("warmup", 0, '0, 1'b0, 1'b0, '0, 1'b0);
      end
      tick(4);
      set_ab(1'b0, 1'b1);
      chk("post_warmup_up", LAT, 32'd1, 1'b1, 1'b0, '0, 1'b0);
      tick(10);

      for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick(1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      checks++;
      if (idx_q.size() != 0) begin
         errors++;
         $display("FAIL index_missing: got %0d index pulses not seen, want 0", idx_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish within time limit, want finish");
      $fatal(1);
   end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Parametrised successor to the single-channel quadrature position counter. Takes raw A/B/Z encoder inputs and synchronises and glitch-filters them. It decodes 4x quadrature steps into a signed, loadable position counter, flags illegal transitions, and reports direction. With index support compiled in, it also captures the position on each index pulse. It sits between the encoder input pins and the motion-control register file, one instance per axis.

## Interface
Parameters:
- COUNT_BITS, 32, width of position, load_value and index_pos (≥ 2).
- FILTER_LEN, 3, consecutive cycles a synchronised input must differ from its filtered value before the filtered value changes (≥ 1).
- INDEX_CLEAR, 0, when 1 each index event also clears position to 0 (index build only).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- quadA  in  1  raw encoder A, asynchronous.
- quadB  in  1  raw encoder B, asynchronous.
- quadZ  in  1  raw encoder index, asynchronous; ignored unless QUAD_INDEX_EN is defined.
- load  in  1  when high, position <= load_value this cycle.
- load_value  in  COUNT_BITS  preset value, signed.
- err_clear  in  1  clears the error flag.
- position  out  COUNT_BITS  signed step count, registered.
- dir  out  1  direction of the last valid step: 1 = up, 0 = down.
- error  out  1  sticky illegal-transition flag.
- index_pos  out  COUNT_BITS  position captured at the last index event.
- index_valid  out  1  one-cycle pulse when index_pos is updated.

## Operation
- Input path, per input (A, B, Z):
  - 2-flop synchroniser.
  - Filter: a counter increments while the synchroniser output differs from the filtered value, and resets to 0 when they match.
  - When the counter reaches FILTER_LEN, the filtered value takes the synchroniser value and the counter resets.
- Decoder: compares the previous filtered state {A,B} with the current one.
  - Up sequence: 00→10→11→01→00 (A leads B).
  - Down sequence: the reverse.
  - No change: hold.
  - Both bits changed: illegal; error <= 1, no count, dir unchanged.
- Counter arithmetic: two's complement modulo 2^COUNT_BITS.
  - Max + 1 wraps to min; min − 1 wraps to max.
  - No saturation and no wrap flag.
- Priority per cycle: rst > load > index clear (INDEX_CLEAR=1) > step.
  - load or index clear in the same cycle as a step discards the step.
  - dir still updates on that step.
- error: err_clear and a new illegal transition in the same cycle leave error = 1 (set wins).
- State machine (two states):
  - WARMUP: entered on rst. Runs for FILTER_LEN+3 cycles after rst deasserts. Filtered and previous states track the inputs; no counting, no error, no index events. This prevents false steps from the reset value 00.
  - RUN: normal decoding.
  - rst asserted in any state returns to WARMUP immediately.
- Reset values: position 0, dir 0, error 0, index_pos 0, index_valid 0. Sync flops, filter counters, filtered and previous states are all 0.

## Timing
- New pin level first sampled at edge k:
  - synchroniser output valid at k+1;
  - filtered value at k+FILTER_LEN+1;
  - position/dir/error at k+FILTER_LEN+2.
- Pulses shorter than FILTER_LEN cycles at the synchroniser output are rejected entirely.
- Maximum step rate: one per FILTER_LEN+1 cycles per input. Faster inputs can produce illegal transitions, which are flagged, not counted.
- load takes effect at the next edge (position = load_value one cycle later).
- index_valid is high for exactly one cycle, concurrent with index_pos changing.

## Configuration
- QUAD_INDEX_EN defined:
  - Z passes through the sync + filter path.
  - Each filtered Z rising edge in RUN captures index_pos <= next position value, including any step or load applied that same cycle, and pulses index_valid.
  - With INDEX_CLEAR=1, position is cleared to 0; index_pos still captures the pre-clear next value, and load still wins over clear.
- QUAD_INDEX_EN undefined:
  - No Z logic is built and quadZ is unused.
  - index_pos stays 0 and index_valid stays 0.
  - INDEX_CLEAR has no effect.

## Test plan
- Reset, then 8 up-steps (00→10→11→01→00 twice, each level held 10 cycles) with FILTER_LEN=3 → position 8, dir 1, error 0. Each increment lands exactly FILTER_LEN+2 cycles after the pin change.
- From 0, one down-step (00→01) → position −1 (all ones); load_value = 2^(COUNT_BITS−1)−1 then one up-step → position = most-negative value.
- A 2-cycle glitch on quadA with FILTER_LEN=3 → no position change. An 00→11 jump held 10 cycles → error 1, position unchanged. err_clear coincident with another illegal jump → error stays 1.
- load=1 with load_value=100 in the same cycle as an up-step → position 100, dir 1.
- QUAD_INDEX_EN, INDEX_CLEAR=1: position 57 with Z rising → index_pos 57, one-cycle index_valid, position 0. Rebuilt without the macro, the same stimulus leaves index_pos 0 and position 57.
- Inputs held at 11 through reset, rst released → no count and no error during WARMUP; the first subsequent up-step (11→01) → position 1.
